// File: rtl/time_event_source.sv
// rtl/time_event_source.sv - scheduled time-event source for the global time-advance protocol
//
// Holds one scheduled event time and proposes it to the central time manager.
// When global time reaches the scheduled time it emits a one-cycle pulse, then
// fetches a signed jitter sample and reschedules at E + period + jitter. Its
// proposal stays at E until the new time is known.
//
// Ports:
//   clk_sys      system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   en           enable scheduling
//   period       nominal event spacing, sampled at the jitter handshake
//   jitter       signed offset sample (two's complement)
//   jit_valid    jitter sample valid
//   jit_ready    block accepts a jitter sample
//   time_curr    registered global time from the time manager
//   time_out     this block's time proposal (decoded from registers only)
//   event_pulse  one-cycle event pulse
//   event_count  events fired, wraps
//   missed       sticky: global time passed the scheduled time

`timescale 1ns/1ps

module time_event_source #(
  parameter int TIME_BITS   = 32,
  parameter int PERIOD_BITS = 16,
  parameter int JITTER_BITS = 12,
  parameter int COUNT_BITS  = 16
) (
  input  logic                   clk_sys,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [PERIOD_BITS-1:0] period,
  input  logic [JITTER_BITS-1:0] jitter,
  input  logic                   jit_valid,
  output logic                   jit_ready,
  input  logic [TIME_BITS-1:0]   time_curr,
  output logic [TIME_BITS-1:0]   time_out,
  output logic                   event_pulse,
  output logic [COUNT_BITS-1:0]  event_count,
  output logic                   missed
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ARMED = 2'd2;

  // Two guard bits: one for sign, one so period + jitter cannot overflow.
  localparam int STEP_BITS = ((PERIOD_BITS > JITTER_BITS) ? PERIOD_BITS : JITTER_BITS) + 2;

  logic [1:0]                 state;
  logic [TIME_BITS-1:0]       base;
  logic [TIME_BITS-1:0]       event_time;

  logic signed [STEP_BITS-1:0] step_raw;
  logic [STEP_BITS-2:0]        step_mag;
  logic [TIME_BITS:0]          sched_sum;
  logic [TIME_BITS-1:0]        sched_time;

  // Next scheduled time: step clamped to at least 1 so the new event is
  // strictly after base; the sum saturates instead of wrapping.
  always_comb begin
    step_raw = $signed({{(STEP_BITS-PERIOD_BITS){1'b0}}, period})
             + $signed({{(STEP_BITS-JITTER_BITS){jitter[JITTER_BITS-1]}}, jitter});
    if (step_raw[STEP_BITS-1] || (step_raw == '0))
      step_mag = {{(STEP_BITS-2){1'b0}}, 1'b1};
    else
      step_mag = step_raw[STEP_BITS-2:0];
    sched_sum  = {1'b0, base} + {{(TIME_BITS+2-STEP_BITS){1'b0}}, step_mag};
    sched_time = sched_sum[TIME_BITS] ? {TIME_BITS{1'b1}} : sched_sum[TIME_BITS-1:0];
  end

  // Proposal depends on registers only, so the time manager sees no
  // combinational loop through time_curr.
  always_comb begin
    case (state)
      FETCH:   time_out = base;
      ARMED:   time_out = event_time;
      default: time_out = {TIME_BITS{1'b1}};
    endcase
  end

  assign jit_ready = (state == FETCH) && en;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      base        <= '0;
      event_time  <= '0;
      event_pulse <= 1'b0;
      event_count <= '0;
      missed      <= 1'b0;
    end else begin
      event_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            base  <= time_curr;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (!en) begin
            state <= IDLE;
          end else if (jit_valid) begin
            event_time <= sched_time;
            state      <= ARMED;
          end
        end
        ARMED: begin
          if (!en) begin
            state <= IDLE;
          end else if (time_curr >= event_time) begin
            // An overshoot still fires and reschedules from event_time so the
            // nominal cadence is kept; it is only flagged.
            if (time_curr != event_time)
              missed <= 1'b1;
            event_pulse <= 1'b1;
            event_count <= event_count + {{(COUNT_BITS-1){1'b0}}, 1'b1};
            base        <= event_time;
            state       <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/time_event_source.md
# time_event_source

Emulated-component side of the global time-advance protocol. It holds one scheduled event time and offers it as its time proposal to the central time manager, which takes the minimum of all proposals as `time_next` and registers it as `time_curr`. When `time_curr` reaches the scheduled time, the block emits a one-cycle event pulse. It then fetches a signed jitter sample over a valid/ready handshake and reschedules at `E + period + jitter`, pinning global time at `E` until the new time is known.

## Interface

- `TIME_BITS`, 32: width of all time values, unsigned, in time LSBs.
- `PERIOD_BITS`, 16: width of `period`, unsigned.
- `JITTER_BITS`, 12: width of `jitter`, two's complement.
- `COUNT_BITS`, 16: width of `event_count`.
- `clk_sys`  input  1  system clock; all state updates on its rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `en`  input  1  enable scheduling.
- `period`  input  PERIOD_BITS  nominal event spacing; sampled at the jitter handshake.
- `jitter`  input  JITTER_BITS  signed offset sample.
- `jit_valid`  input  1  `jitter` is valid.
- `jit_ready`  output  1  block accepts a jitter sample.
- `time_curr`  input  TIME_BITS  registered global time from the time manager.
- `time_out`  output  TIME_BITS  this block's proposal to the time manager.
- `event`  output  1  one-cycle event pulse.
- `event_count`  output  COUNT_BITS  number of events fired; wraps modulo 2^COUNT_BITS.
- `missed`  output  1  sticky error: global time passed the scheduled time.

## Operation

- Registers:
  - `state` ∈ {IDLE, FETCH, ARMED}
  - `base` (TIME_BITS)
  - `event_time` (TIME_BITS)
  - `event`, `event_count`, `missed`
- `time_out` is decoded from registers only; there is no combinational path from `time_curr`.
  - IDLE: all ones, so the block never constrains global time.
  - FETCH: `base`.
  - ARMED: `event_time`.
- `jit_ready` = (state == FETCH) && `en`.
- IDLE:
  - `en`=1 → FETCH, with `base` <= `time_curr`.
- FETCH:
  - `en`=0 → IDLE.
  - Otherwise, on `jit_valid && jit_ready` → ARMED, with `event_time` <= `base` + step.
  - Step = `period` + sign-extended `jitter`, computed at width max(PERIOD_BITS, JITTER_BITS)+2, signed.
  - Step < 1 is clamped to 1, so the scheduled time is always strictly greater than `base`.
  - Sum ≥ 2^TIME_BITS saturates to all ones. An event at all ones never fires; this is acceptable and wrap-around is not supported.
- ARMED:
  - `en`=0 → IDLE; the pending event is discarded and no pulse is emitted.
  - Else if `time_curr` == `event_time`: `event` <= 1, `event_count` += 1, `base` <= `event_time`, → FETCH.
  - Else if `time_curr` > `event_time`: `missed` <= 1, and the block behaves as on match (pulse, reschedule from `event_time`).
- `event` is 1 only in the cycle following a match; otherwise it is 0.
- `missed` clears only on reset.
- Reset (asynchronous, at any point mid-operation):
  - state = IDLE, `time_out` = all ones.
  - `base` = 0, `event_time` = 0.
  - `event` = 0, `event_count` = 0, `missed` = 0, `jit_ready` = 0.

## Timing

- Let cycle k be the cycle in which `time_curr` == E while ARMED.
  - Edge k+1: `event`=1, state FETCH, `time_out`=E.
  - With `jit_valid` held high, edge k+2: state ARMED, `time_out` = E + step, `event`=0.
- Because the proposal never exceeds E from cycle k until the handshake completes, global time stays at E for at least 2 cycles after any event. Peers therefore observe `event` while `time_curr` == E.
- A late `jit_valid` stretches FETCH; global time stays pinned at E for the whole wait.
- First event after enable: `en` rises in cycle j with `time_curr`=T → FETCH at j+1 → ARMED at j+2 earliest, with `event_time` = T + step.
- Handshake: transfer occurs when both `jit_valid` and `jit_ready` are high at a rising edge. `jitter` and `period` are sampled at that edge.

## Test plan

- Reset mid-ARMED (`rst_n` low for 1 ns between edges) → all outputs take reset values immediately; `time_out`=0xFFFFFFFF.
- Basic periodic scheduling:
  - Stimulus: `period`=100, `jitter`=0, `jit_valid`=1, `en` rises at `time_curr`=0, with a bench time manager that takes the min of `time_out` and a peer proposal of all ones.
  - Required: `event` pulses at `time_curr` = 100, 200, 300; `event_count` = 3; `missed` = 0.
- Jitter and clamping:
  - `period`=10, `jitter` = −3 → next event at E+7.
  - `period`=2, `jitter` = −50 → next event at E+1.
- Late handshake:
  - Stimulus: `jit_valid` low for 5 cycles after the event at E=100.
  - Required: `time_out`=100 and `time_curr`=100 for all 5 cycles; next event at 200.
- Disable while ARMED:
  - Stimulus: `en`=0 at `time_curr`=50 with `event_time`=100.
  - Required: IDLE next cycle, no pulse, `time_out`=0xFFFFFFFF.
- Overshoot and saturation:
  - Force `time_curr`=105 with `event_time`=100 → `missed`=1 (sticky), one pulse, next event at 200.
  - `base`=0xFFFFFFF0 with step 100 → `event_time`=0xFFFFFFFF.
